// File: rtl/kick_chip_ctrl.sv
// kick_chip_ctrl: multi-channel solenoid kicker controller.
// One boost-charger enable drives NCH solenoid channels through the cycle
// IDLE -> PRE_GUARD -> FIRE -> POST_GUARD -> COOLDOWN -> IDLE.
// The pulse width is strength * PULSE_UNIT, saturated at MAX_PULSE.
// Optional charge-timeout fault: define KICK_CHG_TIMEOUT_EN.
module kick_chip_ctrl #(
   parameter int NCH             = 2,
   parameter int STRENGTH_W      = 7,
   parameter int PULSE_UNIT      = 8192,
   parameter int MAX_PULSE       = 1048575,
   parameter int PW_W            = 20,
   parameter int GUARD_CYCLES    = 16,
   parameter int COOLDOWN_CYCLES = 4194303,
   parameter int CHG_TIMEOUT     = 268435455,
   localparam int SEL_W          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  kick_req,
   input  logic [SEL_W-1:0]      kick_sel,
   input  logic [STRENGTH_W-1:0] kick_strength,
   input  logic                  charge_en,
   input  logic                  charge_done,
   input  logic                  fault_clr,
   output logic                  charge,
   output logic [NCH-1:0]        trigger,
   output logic                  kick_ack,
   output logic                  busy,
   output logic                  ready,
   output logic                  fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE_GUARD,
      S_FIRE,
      S_POST_GUARD,
      S_COOLDOWN
   } state_t;

   // One down-counter serves every timed state, so it must hold the largest load.
   localparam int CW_A   = (PW_W > $clog2(COOLDOWN_CYCLES + 1)) ? PW_W : $clog2(COOLDOWN_CYCLES + 1);
   localparam int CNT_W  = (CW_A > $clog2(GUARD_CYCLES + 1)) ? CW_A : $clog2(GUARD_CYCLES + 1);
   localparam int PROD_W = STRENGTH_W + 32;

   localparam logic [CNT_W-1:0] G_LOAD = (GUARD_CYCLES > 0)    ? CNT_W'(GUARD_CYCLES - 1)    : '0;
   localparam logic [CNT_W-1:0] C_LOAD = (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

   // Zero-length guard or cooldown phases are skipped entirely.
   localparam state_t AFTER_FIRE = (GUARD_CYCLES != 0)    ? S_POST_GUARD :
                                   (COOLDOWN_CYCLES != 0) ? S_COOLDOWN   : S_IDLE;
   localparam logic [CNT_W-1:0] AFTER_FIRE_LOAD = (GUARD_CYCLES != 0) ? G_LOAD : C_LOAD;
   localparam state_t AFTER_POST = (COOLDOWN_CYCLES != 0) ? S_COOLDOWN : S_IDLE;

   state_t            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [SEL_W-1:0]  sel_q, sel_nxt;
   logic [PW_W-1:0]   plen_q, plen_nxt;
   logic [PROD_W-1:0] prod;
   logic [PW_W-1:0]   plen_in;
   logic              accept;
   logic              fault_q, fault_nxt;

   logic              charge_q, charge_nxt;
   logic [NCH-1:0]    trigger_q, trigger_nxt;
   logic              ack_q, ack_nxt;
   logic              busy_q, busy_nxt;
   logic              ready_q, ready_nxt;

   // Pulse length: full-width product, then saturate at the ceiling.
   always_comb begin
      prod    = PROD_W'(kick_strength) * PROD_W'(PULSE_UNIT);
      plen_in = (prod > PROD_W'(MAX_PULSE)) ? PW_W'(MAX_PULSE) : PW_W'(prod);
      accept  = (state_q == S_IDLE) && kick_req && (kick_strength != '0) &&
                (32'(kick_sel) < 32'(NCH)) && !fault_q;
   end

   // Next-state logic and next values of the registered outputs.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      sel_nxt   = sel_q;
      plen_nxt  = plen_q;
      ack_nxt   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ack_nxt  = 1'b1;
               sel_nxt  = kick_sel;
               plen_nxt = plen_in;
               if (GUARD_CYCLES != 0) begin
                  state_nxt = S_PRE_GUARD;
                  cnt_nxt   = G_LOAD;
               end else begin
                  state_nxt = S_FIRE;
                  cnt_nxt   = CNT_W'(plen_in) - CNT_W'(1);
               end
            end
         end
         S_PRE_GUARD: begin
            if (cnt_q == '0) begin
               state_nxt = S_FIRE;
               cnt_nxt   = CNT_W'(plen_q) - CNT_W'(1);
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         S_FIRE: begin
            if (cnt_q == '0) begin
               state_nxt = AFTER_FIRE;
               cnt_nxt   = AFTER_FIRE_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         S_POST_GUARD: begin
            if (cnt_q == '0) begin
               state_nxt = AFTER_POST;
               cnt_nxt   = C_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         S_COOLDOWN: begin
            if (cnt_q == '0) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Charge only while staying in IDLE, so it returns one edge after re-entry.
      charge_nxt = (state_q == S_IDLE) && (state_nxt == S_IDLE) && charge_en && !fault_nxt;
      busy_nxt   = (state_nxt != S_IDLE);
      ready_nxt  = (state_nxt == S_IDLE) && charge_done && !fault_nxt;
      for (int unsigned i = 0; i < NCH; i++) begin
         trigger_nxt[i] = (state_nxt == S_FIRE) && (32'(sel_nxt) == i);
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         plen_q    <= '0;
         charge_q  <= 1'b0;
         trigger_q <= '0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         sel_q     <= sel_nxt;
         plen_q    <= plen_nxt;
         charge_q  <= charge_nxt;
         trigger_q <= trigger_nxt;
         ack_q     <= ack_nxt;
         busy_q    <= busy_nxt;
         ready_q   <= ready_nxt;
      end
   end

`ifdef KICK_CHG_TIMEOUT_EN
   localparam int TO_W = $clog2(CHG_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(CHG_TIMEOUT - 1);

   logic [TO_W-1:0] tcnt_q, tcnt_nxt;

   // Charge-timeout: count idle charging cycles without charge_done.
   always_comb begin
      tcnt_nxt  = tcnt_q;
      fault_nxt = fault_q;
      if ((state_q == S_IDLE) && fault_clr) begin
         fault_nxt = 1'b0;
         tcnt_nxt  = '0;
      end else if ((state_q == S_IDLE) && charge_q && !charge_done) begin
         if (tcnt_q == TO_LAST) begin
            fault_nxt = 1'b1;
            tcnt_nxt  = '0;
         end else begin
            tcnt_nxt = tcnt_q + TO_W'(1);
         end
      end else begin
         tcnt_nxt = '0;
      end
   end

   // Sticky fault flag and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         fault_q <= fault_nxt;
         tcnt_q  <= tcnt_nxt;
      end
   end
`else
   logic unused_timeout;

   assign fault_q        = 1'b0;
   assign fault_nxt      = 1'b0;
   assign unused_timeout = ^{fault_clr, 32'(CHG_TIMEOUT)};
`endif

   assign charge   = charge_q;
   assign trigger  = trigger_q;
   assign kick_ack = ack_q;
   assign busy     = busy_q;
   assign ready    = ready_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_kick_chip_ctrl.sv
// tb_kick_chip_ctrl: directed self-checking bench for kick_chip_ctrl.
// Main instance NCH=2; a second NCH=3 instance exercises out-of-range select.
module tb_kick_chip_ctrl;

   logic       clk;
   logic       rst_n;
   logic       kick_req;
   logic [0:0] kick_sel;
   logic [6:0] kick_strength;
   logic       charge_en;
   logic       charge_done;
   logic       fault_clr;
   logic       charge;
   logic [1:0] trigger;
   logic       kick_ack;
   logic       busy;
   logic       ready;
   logic       fault;

   logic       req3;
   logic [1:0] sel3;
   logic [6:0] str3;
   logic       charge3;
   logic [2:0] trigger3;
   logic       ack3;
   logic       busy3;
   logic       ready3;
   logic       fault3;

   int tests = 0;
   int fails = 0;

   int cyc;
   int first_t0, last_t0, cnt_t0;
   int first_t1, cnt_t1;
   int cnt_busy, last_busy;
   int cnt_ack, last_ack;
   int chg_busy;
   logic charge_hist [0:511];
   logic ready_hist  [0:511];

   kick_chip_ctrl #(
      .NCH(2), .STRENGTH_W(7), .PULSE_UNIT(4), .MAX_PULSE(200), .PW_W(8),
      .GUARD_CYCLES(3), .COOLDOWN_CYCLES(20), .CHG_TIMEOUT(50)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .kick_req(kick_req), .kick_sel(kick_sel),
      .kick_strength(kick_strength), .charge_en(charge_en), .charge_done(charge_done),
      .fault_clr(fault_clr), .charge(charge), .trigger(trigger), .kick_ack(kick_ack),
      .busy(busy), .ready(ready), .fault(fault)
   );

   kick_chip_ctrl #(
      .NCH(3), .STRENGTH_W(7), .PULSE_UNIT(4), .MAX_PULSE(200), .PW_W(8),
      .GUARD_CYCLES(3), .COOLDOWN_CYCLES(20), .CHG_TIMEOUT(50)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n), .kick_req(req3), .kick_sel(sel3),
      .kick_strength(str3), .charge_en(charge_en), .charge_done(charge_done),
      .fault_clr(fault_clr), .charge(charge3), .trigger(trigger3), .kick_ack(ack3),
      .busy(busy3), .ready(ready3), .fault(fault3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Safety invariants on both instances, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         tests++;
         assert (!(charge && (|trigger)) && $onehot0(trigger)) else begin
            fails++;
            $error("FAIL inv_main: charge %0b trigger %b expected no overlap and onehot0", charge, trigger);
         end
         tests++;
         assert (!(charge3 && (|trigger3)) && $onehot0(trigger3)) else begin
            fails++;
            $error("FAIL inv_nch3: charge %0b trigger %b expected no overlap and onehot0", charge3, trigger3);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      first_t0 = 0; last_t0 = 0; cnt_t0 = 0;
      first_t1 = 0; cnt_t1 = 0;
      cnt_busy = 0; last_busy = 0;
      cnt_ack = 0; last_ack = 0;
      chg_busy = 0;
      for (int i = 0; i < 512; i++) begin
         charge_hist[i] = 1'b0;
         ready_hist[i]  = 1'b0;
      end
   endtask

   // Issue a one-cycle request; cycle 1 is the cycle after the sampling edge.
   task automatic kick(input logic [0:0] sel, input logic [6:0] str);
      kick_sel      = sel;
      kick_strength = str;
      kick_req      = 1'b1;
      tick();
      kick_req      = 1'b0;
      cyc           = 1;
   endtask

   task automatic observe(input int n);
      repeat (n) begin
         if (trigger[0]) begin
            if (first_t0 == 0) first_t0 = cyc;
            last_t0 = cyc;
            cnt_t0++;
         end
         if (trigger[1]) begin
            if (first_t1 == 0) first_t1 = cyc;
            cnt_t1++;
         end
         if (busy) begin
            cnt_busy++;
            last_busy = cyc;
            if (charge) chg_busy++;
         end
         if (kick_ack) begin
            cnt_ack++;
            last_ack = cyc;
         end
         if (cyc < 512) begin
            charge_hist[cyc] = charge;
            ready_hist[cyc]  = ready;
         end
         tick();
         cyc++;
      end
   endtask

   initial begin
      int n;
      int t2, tlo;
      rst_n = 1'b0; kick_req = 1'b0; kick_sel = '0; kick_strength = '0;
      charge_en = 1'b0; charge_done = 1'b0; fault_clr = 1'b0;
      req3 = 1'b0; sel3 = '0; str3 = '0;
      cyc = 0;
      #2;
      check("rst_charge", 32'(charge), 0);
      check("rst_trigger", 32'(trigger), 0);
      check("rst_ack", 32'(kick_ack), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_fault", 32'(fault), 0);
      tick(); tick();
      rst_n = 1'b1;
      charge_en = 1'b1;
      charge_done = 1'b1;
      tick();
      check("idle_charge", 32'(charge), 1);
      check("idle_ready", 32'(ready), 1);

      // Basic kick: strength 5 -> 20 trigger cycles
      clear_stats();
      kick(1'b0, 7'd5);
      observe(50);
      check("basic_ack_cnt", 32'(cnt_ack), 1);
      check("basic_ack_cyc", 32'(last_ack), 1);
      check("basic_t0_first", 32'(first_t0), 4);
      check("basic_t0_last", 32'(last_t0), 23);
      check("basic_t0_cnt", 32'(cnt_t0), 20);
      check("basic_t1_cnt", 32'(cnt_t1), 0);
      check("basic_busy_cnt", 32'(cnt_busy), 46);
      check("basic_busy_last", 32'(last_busy), 46);
      check("basic_chg_busy", 32'(chg_busy), 0);
      check("basic_chg_c47", 32'(charge_hist[47]), 0);
      check("basic_chg_c48", 32'(charge_hist[48]), 1);
      check("basic_rdy_c46", 32'(ready_hist[46]), 0);
      check("basic_rdy_c47", 32'(ready_hist[47]), 1);

      // Saturation: 127*4 = 508 -> 200
      clear_stats();
      kick(1'b1, 7'd127);
      observe(230);
      check("sat_ack_cnt", 32'(cnt_ack), 1);
      check("sat_t1_first", 32'(first_t1), 4);
      check("sat_t1_cnt", 32'(cnt_t1), 200);
      check("sat_t0_cnt", 32'(cnt_t0), 0);
      check("sat_busy_cnt", 32'(cnt_busy), 226);

      // Strength 0 rejected
      clear_stats();
      kick(1'b0, 7'd0);
      observe(10);
      check("rej0_ack", 32'(cnt_ack), 0);
      check("rej0_busy", 32'(cnt_busy), 0);
      check("rej0_trig", 32'(cnt_t0 + cnt_t1), 0);

      // Out-of-range select on NCH=3 instance, then a valid one
      sel3 = 2'd3; str3 = 7'd1; req3 = 1'b1;
      tick();
      req3 = 1'b0;
      check("rejsel_ack", 32'(ack3), 0);
      check("rejsel_busy", 32'(busy3), 0);
      sel3 = 2'd2; req3 = 1'b1;
      tick();
      req3 = 1'b0;
      check("sel2_ack", 32'(ack3), 1);
      t2 = 0; tlo = 0;
      repeat (20) begin
         if (trigger3[2]) t2++;
         if (|trigger3[1:0]) tlo++;
         tick();
      end
      check("sel2_t2_cnt", 32'(t2), 4);
      check("sel2_tlo_cnt", 32'(tlo), 0);

      // Request during FIRE ignored; request on return-to-IDLE edge ignored
      clear_stats();
      kick(1'b0, 7'd2);
      observe(4);
      kick_sel = 1'b1; kick_strength = 7'd5; kick_req = 1'b1;
      observe(1);
      kick_req = 1'b0;
      observe(28);
      kick_sel = 1'b1; kick_strength = 7'd1; kick_req = 1'b1;
      observe(2);
      kick_req = 1'b0;
      observe(35);
      check("busyreq_ack_cnt", 32'(cnt_ack), 2);
      check("busyreq_ack_last", 32'(last_ack), 36);
      check("busyreq_t0_first", 32'(first_t0), 4);
      check("busyreq_t0_cnt", 32'(cnt_t0), 8);
      check("busyreq_t1_first", 32'(first_t1), 39);
      check("busyreq_t1_cnt", 32'(cnt_t1), 4);
      check("busyreq_busy_cnt", 32'(cnt_busy), 64);
      check("busyreq_busy_last", 32'(last_busy), 65);

      // Asynchronous reset during FIRE
      clear_stats();
      kick(1'b0, 7'd5);
      observe(12);
      check("midrst_pre_trig", 32'(trigger), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_trig", 32'(trigger), 0);
      check("midrst_charge", 32'(charge), 0);
      check("midrst_busy", 32'(busy), 0);
      charge_done = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("postrst_busy", 32'(busy), 0);
      check("postrst_ready_lo", 32'(ready), 0);
      check("postrst_charge", 32'(charge), 1);
      charge_done = 1'b1;
      tick();
      check("postrst_ready_hi", 32'(ready), 1);

`ifdef KICK_CHG_TIMEOUT_EN
      charge_done = 1'b0;
      n = 0;
      while ((fault !== 1'b1) && (n < 100)) begin
         tick();
         n++;
      end
      check("to_cycles", 32'(n), 50);
      check("to_charge", 32'(charge), 0);
      clear_stats();
      kick(1'b0, 7'd5);
      check("to_rej_ack", 32'(kick_ack), 0);
      check("to_rej_busy", 32'(busy), 0);
      check("to_fault_sticky", 32'(fault), 1);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("to_clr_fault", 32'(fault), 0);
      check("to_clr_charge", 32'(charge), 1);
      charge_done = 1'b1;
`else
      charge_done = 1'b0;
      n = 0;
      repeat (60) tick();
      check("nofeat_fault", 32'(fault), 0);
      check("nofeat_charge", 32'(charge), 1);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("nofeat_fault_clr", 32'(fault), 0);
      charge_done = 1'b1;
`endif
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
